fetch_buffer: RTL and testbench

Instruction queue between the fetch stage and the decode stage. Fetch pushes one 32-bit instruction with its PC per cycle. The buffer presents the oldest entry to decode as `o_instr` / `o_pc`, with `o_imask` marking it valid, and pops it when decode accepts. The buffer absorbs decode/dispatch back-pressure and is emptied in one cycle on a branch-mispredict flush.

---
 rtl/fetch_buffer_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 83 ++++++++
 tb/tb_fetch_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_buffer_pkg : shared constants for the fetch-to-decode instruction queue
// Revision: 1.0
// ---------------------------------------------------------------------------
package fetch_buffer_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) shown on the head when the queue is empty
  localparam logic [31:0] FB_NOP = 32'h00000013;

  // Pointer width: index bits plus one wrap bit
  function automatic int fb_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_buffer : show-ahead instruction FIFO between fetch and decode,
//                single-cycle flush on redirect
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH_PC = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush,
  input  logic                        i_valid,
  input  logic [31:0]                 i_instr,
  input  logic [WIDTH_PC-1:0]         i_pc,
  output logic                        o_ready,
  input  logic                        i_ready,
  output logic                        o_imask,
  output logic [31:0]                 o_instr,
  output logic [WIDTH_PC-1:0]         o_pc,
  output logic [$clog2(DEPTH):0]      o_count
);

  localparam int                 c_PTR_W = fb_ptr_w(DEPTH);
  localparam int                 c_IDX_W = c_PTR_W - 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  logic [31:0]         r_mem_instr [DEPTH];
  logic [WIDTH_PC-1:0] r_mem_pc    [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;

  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;

  assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) &&
                    (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]);

  // Readiness depends only on registered occupancy, so a full buffer never
  // reuses the slot being popped in the same cycle.
  assign w_push = i_valid && !w_full  && !i_flush;
  assign w_pop  = i_ready && !w_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Storage is intentionally not cleared on reset or flush; the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem_instr[w_wr_idx] <= i_instr;
      r_mem_pc[w_wr_idx]    <= i_pc;
    end
  end

  assign o_ready = !w_full;
  assign o_imask = !w_empty;
  assign o_instr = w_empty ? FB_NOP : r_mem_instr[w_rd_idx];
  assign o_pc    = w_empty ? '0     : r_mem_pc[w_rd_idx];
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_buffer : directed + randomized bench against a queue reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam int          DEPTH    = 8;
  localparam int          WIDTH_PC = 32;
  localparam logic [31:0] c_NOP    = 32'h00000013;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_flush = 1'b0;
  logic                 i_valid = 1'b0;
  logic [31:0]          i_instr = '0;
  logic [WIDTH_PC-1:0]  i_pc = '0;
  logic                 o_ready;
  logic                 i_ready = 1'b0;
  logic                 o_imask;
  logic [31:0]          o_instr;
  logic [WIDTH_PC-1:0]  o_pc;
  logic [$clog2(DEPTH):0] o_count;

  fetch_buffer #(.DEPTH(DEPTH), .WIDTH_PC(WIDTH_PC)) u_dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_instr (i_instr),
    .i_pc    (i_pc),
    .o_ready (o_ready),
    .i_ready (i_ready),
    .o_imask (o_imask),
    .o_instr (o_instr),
    .o_pc    (o_pc),
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference: the buffer is simply an ordered list of {instr, pc}
  logic [63:0] r_model_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = r_model_q.size();
    check("imask", 64'(o_imask), 64'(sz != 0));
    check("ready", 64'(o_ready), 64'(sz < DEPTH));
    check("count", 64'(o_count), 64'(sz));
    check("instr", 64'(o_instr), (sz != 0) ? 64'(r_model_q[0][63:32]) : 64'(c_NOP));
    check("pc",    64'(o_pc),    (sz != 0) ? 64'(r_model_q[0][31:0])  : 64'd0);
  endtask

  // Called at a negedge: check current head, drive next inputs, advance model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic rs);
    int   sz;
    logic do_pop;
    logic do_push;
    check_outputs();
    i_valid = v;
    i_instr = ins;
    i_pc    = pc;
    i_ready = rdy;
    i_flush = fl;
    i_rst   = rs;
    if (rs || fl) begin
      r_model_q.delete();
    end else begin
      sz      = r_model_q.size();
      do_pop  = (sz > 0) && rdy;
      do_push = v && (sz < DEPTH);
      if (do_pop)  void'(r_model_q.pop_front());
      if (do_push) r_model_q.push_back({ins, pc});
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic push_n(input int n, input logic rdy);
    for (int k = 0; k < n; k++)
      cycle(1'b1, $urandom, $urandom, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    r_model_q.delete();

    // Idle after reset
    repeat (2) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Fill with back-pressure, then attempt a 9th push
    for (int k = 0; k < DEPTH; k++)
      cycle(1'b1, 32'h00100093 + 32'(k), 32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 32'h200, 1'b0, 1'b0, 1'b0);

    // Drain
    for (int k = 0; k < DEPTH + 1; k++)
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Streaming push+pop, enough to wrap the pointers
    push_n(20, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush at count 5 with a push in the same cycle
    push_n(5, 1'b0);
    cycle(1'b1, 32'hBADC0DE0, 32'h300, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h12345678, 32'h400, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Full with push+pop: pop wins, push refused, accepted next cycle
    push_n(DEPTH, 1'b0);
    cycle(1'b1, 32'hAAAA0001, 32'h500, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA0002, 32'h504, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation
    cycle(1'b1, 32'h55555555, 32'h600, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, $urandom,
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 150) == 0));
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
